// File: rtl/multi_counter_bank.sv
// rtl/multi_counter_bank.sv - bank of NUM_CH counters with clear/load/saturate and overflow tracking
// Optional snapshot capture port set enabled by MULTI_COUNTER_BANK_SNAPSHOT_EN.
module multi_counter_bank #(
  parameter int WIDTH   = 8,
  parameter int NUM_CH  = 4,
  parameter int SLICE_W = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          en,
  input  logic [NUM_CH-1:0]          clr,
  input  logic                       load,
  input  logic [CH_W-1:0]            load_ch,
  input  logic [WIDTH-1:0]           load_val,
  input  logic [NUM_CH-1:0]          mode_sat,
  output logic [NUM_CH*WIDTH-1:0]    count_out,
  output logic [NUM_CH-1:0]          status_msb,
  output logic [NUM_CH*SLICE_W-1:0]  partial_data,
  output logic [NUM_CH-1:0]          wrap_pulse,
  output logic [NUM_CH-1:0]          ovf
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
  ,
  input  logic                       snap_req,
  output logic [NUM_CH*WIDTH-1:0]    snap_data,
  output logic                       snap_valid
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0]  cnt_q [NUM_CH];
  logic [WIDTH-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;
  logic [NUM_CH-1:0] wrap_q;
  logic [NUM_CH-1:0] wrap_d;

  // Out-of-range load_ch never matches any i, so such loads are dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      ovf_d[i]  = ovf_q[i];
      wrap_d[i] = 1'b0;
      if (clr[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (load && (int'(load_ch) == i)) begin
        cnt_d[i] = load_val;
        ovf_d[i] = 1'b0;
      end else if (en[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
          if (!mode_sat[i]) begin
            cnt_d[i]  = '0;
            wrap_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q  <= '0;
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q  <= ovf_d;
      wrap_q <= wrap_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign count_out[g*WIDTH +: WIDTH]        = cnt_q[g];
    assign status_msb[g]                      = cnt_q[g][WIDTH-1];
    assign partial_data[g*SLICE_W +: SLICE_W] = cnt_q[g][SLICE_W-1:0];
  end

  assign wrap_pulse = wrap_q;
  assign ovf        = ovf_q;

`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
  logic [NUM_CH*WIDTH-1:0] cnt_d_flat;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_snap
    assign cnt_d_flat[g*WIDTH +: WIDTH] = cnt_d[g];
  end

  // Capture the post-edge values so snap_data matches the next count_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_data  <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) begin
        snap_data <= cnt_d_flat;
      end
    end
  end
`endif

endmodule

// File: doc/multi_counter_bank.md
Name: multi_counter_bank

Overview:
Parametrised bank of NUM_CH independent free-running counters. Each counter's full value, MSB status bit and low-order slice are exported as dedicated output ports. Consumers in the parent module read these ports directly instead of reaching into the counter hierarchy. This is the generalised successor of the single 8-bit counter sub-block, adding per-channel enable, clear, load, saturate mode and overflow tracking.

Parameters:
WIDTH, 8, counter width in bits (>= 2)
NUM_CH, 4, number of counter channels (>= 1)
SLICE_W, 4, width of exported low-order slice (1..WIDTH)
CH_W, $clog2(NUM_CH) min 1, width of load channel index (localparam, derived)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel count enable
clr  input  NUM_CH  per-channel synchronous clear
load  input  1  load strobe
load_ch  input  CH_W  channel index for load
load_val  input  WIDTH  value to load
mode_sat  input  NUM_CH  per-channel mode: 0 = wrap, 1 = saturate at all-ones
count_out  output  NUM_CH*WIDTH  counter values; channel i at [i*WIDTH +: WIDTH]
status_msb  output  NUM_CH  count[i][WIDTH-1]
partial_data  output  NUM_CH*SLICE_W  count[i][SLICE_W-1:0], channel i at [i*SLICE_W +: SLICE_W]
wrap_pulse  output  NUM_CH  one-cycle pulse when channel i wraps max -> 0
ovf  output  NUM_CH  sticky overflow flag per channel

Behaviour:
- Reset (rst_n low, asynchronous): all counters 0, wrap_pulse 0, ovf 0. Hence count_out, status_msb and partial_data are 0. Release is synchronous to clk.
- Per-channel priority at each rising edge: clr[i] > (load && load_ch == i) > en[i] increment > hold.
- clr[i]: count <= 0, ovf[i] <= 0, wrap_pulse[i] <= 0.
- Load: count <= load_val, ovf[i] <= 0. A load_ch value >= NUM_CH is ignored; no channel changes.
- Increment by 1 when en[i]=1:
  - Wrap mode: modulo 2^WIDTH. Max (all-ones) -> 0 sets wrap_pulse[i]=1 for exactly that cycle and sets ovf[i].
  - Saturate mode: at all-ones the count holds, ovf[i] is set, wrap_pulse[i] stays 0.
- wrap_pulse is registered and asserts in the same cycle count_out first shows 0. It deasserts the next cycle unless the channel wraps again, which is only possible with WIDTH where max+1 wraps in one step.
- ovf is sticky and cleared only by reset, clr[i] or a load of channel i.
- Latency: count_out updates one cycle after the enabling edge. status_msb and partial_data are combinational slices of the count register, with no extra latency.
- mode_sat may change at any time and takes effect on the next increment. Switching wrap -> sat at max does not alter the count.
- Channels are fully independent. Simultaneous clr on channel j and load on channel j: clr wins. Loads to different channels in different cycles do not interact.

Optional Feature:
Macro MULTI_COUNTER_BANK_SNAPSHOT_EN.
- With macro: extra ports are added:
  - snap_req input 1
  - snap_data output NUM_CH*WIDTH
  - snap_valid output 1
- On snap_req=1, all counters' post-edge values are captured atomically into snap_data, and snap_valid pulses 1 for one cycle. In other words, snap_data equals count_out of the cycle after the request.
- snap_data holds until the next snap_req. Reset clears snap_data and snap_valid.
- Back-to-back requests re-capture every cycle, with snap_valid held high.
- Without macro: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-count at channel 0 = 8'h5A -> count_out, ovf and wrap_pulse go to 0 immediately without waiting for clk. After release with en=4'hF, each channel reads 1 after the first edge.
- Wrap: load ch2 = 8'hFE, en[2]=1, mode_sat[2]=0 -> ch2 counts FF, then 00 with wrap_pulse[2]=1 for one cycle, ovf[2]=1. status_msb[2] goes 1 -> 0 and partial_data[2] goes F -> 0.
- Saturate: load ch1 = 8'hFD, mode_sat[1]=1, en[1]=1 for 5 cycles -> ch1 reaches FF and holds, ovf[1]=1, wrap_pulse[1] never asserts.
- Priority: same edge with clr[3]=1, load=1, load_ch=3, load_val=8'h77, en[3]=1 -> ch3=00. Next edge with load only -> ch3=77 and ovf[3]=0.
- Partial/MSB slices: load ch0 = 8'hA7 -> count_out[7:0]=A7, status_msb[0]=1, partial_data[3:0]=7. Other channels are unaffected.
- Snapshot (macro on): counters free-running, assert snap_req for 1 cycle when ch0 = 0x10 -> snap_valid pulses once and snap_data[7:0]=0x11. The value holds while counters advance.
